retire_trace_monitor: RTL and testbench
=======================================

# retire_trace_monitor

Synthesizable commit-side observer placed directly downstream of the CPU's retire/debug outputs. It captures up to two retired-instruction addresses per cycle into an ordered trace FIFO, drains them one per cycle over a valid/ready port, and keeps cycle and retire counters. It also runs the end-of-run state machine: normal finish on `done`, or watchdog timeout after `MAX_CYCLES`.

## Interface
- `ADDR_WIDTH`, 32: retire address width.
- `CNT_WIDTH`, 32: width of cycle/retire counters and sequence tags.
- `DEPTH`, 16: trace FIFO entries; power of two, ≥ 2.
- `MAX_CYCLES`, 6000: watchdog limit in RUN cycles.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `retire_valid_0` / `retire_addr_0` in 1 / ADDR_WIDTH: older retire slot.
- `retire_valid_1` / `retire_addr_1` in 1 / ADDR_WIDTH: younger retire slot.
- `done` in 1: CPU end-of-program indication.
- `trace_ready` in 1: consumer accepts head entry.
- `trace_valid` out 1: FIFO non-empty.
- `trace_addr` out ADDR_WIDTH: head entry address.
- `trace_seq` out CNT_WIDTH: head entry sequence number (0-based retire order).
- `n_cycles` out CNT_WIDTH: cycles spent in RUN.
- `n_retired` out CNT_WIDTH: retire events seen in RUN, dropped ones included.
- `overflow` out 1: sticky; set when any retire event was dropped.
- `finished` out 1: state == FINISHED.
- `timeout` out 1: state == TIMEOUT.

## Operation
- States: RUN (after reset), DRAIN, FINISHED, TIMEOUT.
- RUN: `n_cycles` += 1 every cycle; retire events are captured.
  - `done`=1 → DRAIN.
  - Else `n_cycles` == MAX_CYCLES-1 → TIMEOUT.
  - `done` has priority over the watchdog.
- DRAIN: no capture, counters frozen. FIFO empty (after this cycle's pop) → FINISHED.
- FINISHED and TIMEOUT are terminal until reset. FIFO keeps draining in both. Capture and counters stay frozen.
- Capture (RUN only, including the cycle `done` or the watchdog fires):
  - Valid slots are ordered slot 0 then slot 1. A lone `retire_valid_1` is legal and captured alone.
  - Each captured entry stores its address and seq = `n_retired` + its index among this cycle's valid slots.
  - `n_retired` += number of valid slots, whether or not they were stored.
- Space rule: free = DEPTH − count at the start of the cycle. A pop in the same cycle does not free space for that cycle's writes.
  - Valid slots are stored in order while free > 0. The rest are dropped and `overflow` is set.
- Pop when `trace_valid` && `trace_ready`. Simultaneous pop and push both apply: count += pushes − pop.
- Pointers wrap modulo DEPTH. Count is held in log2(DEPTH)+1 bits.
- Counters wrap at 2^CNT_WIDTH with no saturation.

## Timing
- Reset values: `trace_valid`=0, `trace_addr`=0, `trace_seq`=0, `n_cycles`=0, `n_retired`=0, `overflow`=0, `finished`=0, `timeout`=0. FIFO is empty and state is RUN.
- Reset asserted mid-run clears everything immediately, independent of the clock. Contents in flight are discarded.
- Capture latency: a retire sampled at edge N appears as `trace_valid` head (if FIFO was empty) after edge N.
- Head outputs are registered storage reads. They are stable while `trace_valid` && !`trace_ready`.
- Throughput: 2 in/cycle, 1 out/cycle.
- `finished` rises the cycle after the edge at which DRAIN sees the FIFO empty. If the FIFO is empty when `done` is sampled, the sequence is RUN → DRAIN → FINISHED on successive edges.
- `timeout` rises after the edge at which `n_cycles` goes from MAX_CYCLES-1 to MAX_CYCLES.

## Test plan
- DEPTH=4, `trace_ready`=1. Retire both slots with 0x00, 0x04; next cycle slot 0 only with 0x08 → outputs (0x00,seq0), (0x04,seq1), (0x08,seq2) on consecutive cycles; `n_retired`=3.
- `trace_ready`=0. Three dual retires (0x10..0x24) → FIFO holds 0x10, 0x14, 0x18, 0x1C; 0x20 and 0x24 dropped; `overflow`=1; `n_retired`=6. Then assert ready → exactly 4 pops with seq 0–3.
- FIFO full (count=4), dual retire together with a pop → nothing stored, `overflow`=1, count=3.
- `done` with dual retire 0x40, 0x44 and 2 entries already queued, ready=1 → all 4 drain in order. `finished`=1 one cycle after the last pop. `n_cycles` frozen; later retires ignored.
- MAX_CYCLES=20, no `done` → `timeout`=1 after edge 20; `n_cycles`=20 and holds. The same cycle asserting `done` at `n_cycles`=19 → DRAIN wins, `timeout` stays 0.
- Assert `rst` asynchronously mid-drain with 3 entries → all outputs zero immediately. After release, RUN resumes with seq restarting at 0.

Source files
------------

// File: rtl/retire_trace_monitor.sv
// Commit-side observer: captures up to two retired addresses per cycle into an
// ordered trace FIFO, drains one per cycle, and runs the end-of-run FSM.
module retire_trace_monitor #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32,
   parameter int DEPTH      = 16,
   parameter int MAX_CYCLES = 6000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  retire_valid_0,
   input  logic [ADDR_WIDTH-1:0] retire_addr_0,
   input  logic                  retire_valid_1,
   input  logic [ADDR_WIDTH-1:0] retire_addr_1,
   input  logic                  done,
   input  logic                  trace_ready,
   output logic                  trace_valid,
   output logic [ADDR_WIDTH-1:0] trace_addr,
   output logic [CNT_WIDTH-1:0]  trace_seq,
   output logic [CNT_WIDTH-1:0]  n_cycles,
   output logic [CNT_WIDTH-1:0]  n_retired,
   output logic                  overflow,
   output logic                  finished,
   output logic                  timeout
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_FINISHED,
      ST_TIMEOUT
   } state_e;

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [CNT_WIDTH-1:0]  n_cycles_q, n_cycles_d;
   logic [CNT_WIDTH-1:0]  n_retired_q, n_retired_d;
   logic                  overflow_q, overflow_d;

   logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
   logic [CNT_WIDTH-1:0]  mem_seq  [DEPTH];

   logic                  capture;
   logic                  v0, v1;
   logic [1:0]            n_valid, n_push;
   logic [CNT_W-1:0]      free;
   logic                  push0, push1, pop;
   logic [ADDR_WIDTH-1:0] first_addr;
   logic [PTR_W-1:0]      wr_ptr_nxt;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      capture     = (state_q == ST_RUN);
      v0          = capture & retire_valid_0;
      v1          = capture & retire_valid_1;
      n_valid     = {1'b0, v0} + {1'b0, v1};
      // Space is judged against the start-of-cycle count; a same-cycle pop frees nothing.
      free        = CNT_W'(DEPTH) - count_q;
      push0       = (v0 | v1) && (free != '0);
      push1       = (v0 & v1) && (free >= CNT_W'(2));
      n_push      = {1'b0, push0} + {1'b0, push1};
      first_addr  = v0 ? retire_addr_0 : retire_addr_1;
      wr_ptr_nxt  = wr_ptr_q + PTR_W'(1);
      pop         = (count_q != '0) && trace_ready;
      count_d     = count_q + CNT_W'(n_push) - CNT_W'(pop);
      wr_ptr_d    = wr_ptr_q + PTR_W'(n_push);
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      overflow_d  = overflow_q | (n_valid != n_push);
      n_retired_d = n_retired_q + CNT_WIDTH'(n_valid);
      n_cycles_d  = capture ? n_cycles_q + CNT_WIDTH'(1) : n_cycles_q;

      unique case (state_q)
         ST_RUN: begin
            if (done)
               state_d = ST_DRAIN;
            else if (n_cycles_q == CNT_WIDTH'(MAX_CYCLES - 1))
               state_d = ST_TIMEOUT;
         end
         ST_DRAIN: begin
            if (count_d == '0)
               state_d = ST_FINISHED;
         end
         default: state_d = state_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         n_cycles_q  <= '0;
         n_retired_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         n_cycles_q  <= n_cycles_d;
         n_retired_q <= n_retired_d;
         overflow_q  <= overflow_d;
      end
   end

   // NOTE: storage is not reset; empty slots are never visible because the head is gated by trace_valid.
   always_ff @(posedge clk) begin
      if (push0) begin
         mem_addr[wr_ptr_q] <= first_addr;
         mem_seq[wr_ptr_q]  <= n_retired_q;
      end
      if (push1) begin
         mem_addr[wr_ptr_nxt] <= retire_addr_1;
         mem_seq[wr_ptr_nxt]  <= n_retired_q + CNT_WIDTH'(1);
      end
   end

   assign trace_valid = (count_q != '0);
   assign trace_addr  = trace_valid ? mem_addr[rd_ptr_q] : '0;
   assign trace_seq   = trace_valid ? mem_seq[rd_ptr_q]  : '0;
   assign n_cycles    = n_cycles_q;
   assign n_retired   = n_retired_q;
   assign overflow    = overflow_q;
   assign finished    = (state_q == ST_FINISHED);
   assign timeout     = (state_q == ST_TIMEOUT);

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Directed bench for retire_trace_monitor (DEPTH=4, MAX_CYCLES=20): vector table
// plus hand-written sequences for watchdog and asynchronous reset.
module tb_retire_trace_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        retire_valid_0, retire_valid_1;
   logic [31:0] retire_addr_0, retire_addr_1;
   logic        done, trace_ready;
   logic        trace_valid;
   logic [31:0] trace_addr, trace_seq, n_cycles, n_retired;
   logic        overflow, finished, timeout;

   int errors = 0;
   int checks = 0;

   retire_trace_monitor #(
      .ADDR_WIDTH(32), .CNT_WIDTH(32), .DEPTH(4), .MAX_CYCLES(20)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .retire_valid_0(retire_valid_0),
      .retire_addr_0 (retire_addr_0),
      .retire_valid_1(retire_valid_1),
      .retire_addr_1 (retire_addr_1),
      .done          (done),
      .trace_ready   (trace_ready),
      .trace_valid   (trace_valid),
      .trace_addr    (trace_addr),
      .trace_seq     (trace_seq),
      .n_cycles      (n_cycles),
      .n_retired     (n_retired),
      .overflow      (overflow),
      .finished      (finished),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rb;
      bit          v0;
      logic [31:0] a0;
      bit          v1;
      logic [31:0] a1;
      bit          dn;
      bit          rdy;
      bit          e_tv;
      logic [31:0] e_addr;
      logic [31:0] e_seq;
      logic [31:0] e_nret;
      logic [31:0] e_ncyc;
      bit          e_ovf;
      bit          e_fin;
      bit          e_tmo;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input bit rb, input bit v0, input int a0,
                               input bit v1, input int a1, input bit dn, input bit rdy,
                               input bit tv, input int ea, input int es,
                               input int enr, input int enc,
                               input bit ov, input bit fn, input bit to);
      vec_t v;
      v.rb = rb;   v.v0 = v0;    v.a0 = a0;     v.v1 = v1;     v.a1 = a1;
      v.dn = dn;   v.rdy = rdy;  v.e_tv = tv;   v.e_addr = ea; v.e_seq = es;
      v.e_nret = enr; v.e_ncyc = enc; v.e_ovf = ov; v.e_fin = fn; v.e_tmo = to;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      retire_valid_0 = 1'b0; retire_addr_0 = '0;
      retire_valid_1 = 1'b0; retire_addr_1 = '0;
      done = 1'b0; trace_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_all(input string tag, input bit tv, input logic [31:0] ea,
                            input logic [31:0] es, input logic [31:0] enr,
                            input logic [31:0] enc, input bit ov, input bit fn, input bit to);
      check({tag, ".valid"},    32'(trace_valid), 32'(tv));
      check({tag, ".addr"},     trace_addr, ea);
      check({tag, ".seq"},      trace_seq, es);
      check({tag, ".n_retired"}, n_retired, enr);
      check({tag, ".n_cycles"}, n_cycles, enc);
      check({tag, ".overflow"}, 32'(overflow), 32'(ov));
      check({tag, ".finished"}, 32'(finished), 32'(fn));
      check({tag, ".timeout"},  32'(timeout), 32'(to));
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();

      // dual then single retire, consumer always ready
      vecs.push_back(mk(1, 1,'h00, 1,'h04, 0,1,  1,'h00,0, 2,1, 0,0,0));
      vecs.push_back(mk(0, 1,'h08, 0,'h00, 0,1,  1,'h04,1, 3,2, 0,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  1,'h08,2, 3,3, 0,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  0,'h00,0, 3,4, 0,0,0));
      // fill with consumer stalled, two drops, then exactly four pops
      vecs.push_back(mk(1, 1,'h10, 1,'h14, 0,0,  1,'h10,0, 2,1, 0,0,0));
      vecs.push_back(mk(0, 1,'h18, 1,'h1C, 0,0,  1,'h10,0, 4,2, 0,0,0));
      vecs.push_back(mk(0, 1,'h20, 1,'h24, 0,0,  1,'h10,0, 6,3, 1,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  1,'h14,1, 6,4, 1,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  1,'h18,2, 6,5, 1,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  1,'h1C,3, 6,6, 1,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  0,'h00,0, 6,7, 1,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  0,'h00,0, 6,8, 1,0,0));
      // full FIFO: dual retire with a pop stores nothing, count drops to 3
      vecs.push_back(mk(1, 1,'h50, 1,'h54, 0,0,  1,'h50,0, 2,1, 0,0,0));
      vecs.push_back(mk(0, 1,'h58, 1,'h5C, 0,0,  1,'h50,0, 4,2, 0,0,0));
      vecs.push_back(mk(0, 1,'h60, 1,'h64, 0,1,  1,'h54,1, 6,3, 1,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  1,'h58,2, 6,4, 1,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  1,'h5C,3, 6,5, 1,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  0,'h00,0, 6,6, 1,0,0));
      // lone slot 1 retire, then dual with a pop
      vecs.push_back(mk(1, 0,'h00, 1,'hB4, 0,0,  1,'hB4,0, 1,1, 0,0,0));
      vecs.push_back(mk(0, 1,'hB8, 1,'hBC, 0,1,  1,'hB8,1, 3,2, 0,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  1,'hBC,2, 3,3, 0,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  0,'h00,0, 3,4, 0,0,0));
      // done with a dual retire and entries queued: drain, finish, freeze
      vecs.push_back(mk(1, 1,'h30, 1,'h34, 0,0,  1,'h30,0, 2,1, 0,0,0));
      vecs.push_back(mk(0, 1,'h40, 1,'h44, 1,1,  1,'h34,1, 4,2, 0,0,0));
      vecs.push_back(mk(0, 1,'h99, 0,'h00, 0,1,  1,'h40,2, 4,2, 0,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  1,'h44,3, 4,2, 0,0,0));
      vecs.push_back(mk(0, 0,'h00, 0,'h00, 0,1,  0,'h00,0, 4,2, 0,1,0));
      vecs.push_back(mk(0, 1,'hA0, 1,'hA4, 1,1,  0,'h00,0, 4,2, 0,1,0));

      foreach (vecs[i]) begin
         if (vecs[i].rb) begin
            do_reset();
            check_all($sformatf("v%0d.reset", i), 0, 0, 0, 0, 0, 0, 0, 0);
         end
         retire_valid_0 = vecs[i].v0; retire_addr_0 = vecs[i].a0;
         retire_valid_1 = vecs[i].v1; retire_addr_1 = vecs[i].a1;
         done = vecs[i].dn; trace_ready = vecs[i].rdy;
         @(posedge clk);
         #1;
         check_all($sformatf("v%0d", i), vecs[i].e_tv, vecs[i].e_addr, vecs[i].e_seq,
                   vecs[i].e_nret, vecs[i].e_ncyc, vecs[i].e_ovf, vecs[i].e_fin, vecs[i].e_tmo);
      end

      // watchdog fires on the edge taking n_cycles from 19 to 20, then holds
      do_reset();
      repeat (19) @(posedge clk);
      #1;
      check("wd.pre_cycles", n_cycles, 19);
      check("wd.pre_timeout", 32'(timeout), 0);
      @(posedge clk);
      #1;
      check("wd.cycles", n_cycles, 20);
      check("wd.timeout", 32'(timeout), 1);
      repeat (3) @(posedge clk);
      #1;
      check("wd.hold_cycles", n_cycles, 20);
      check("wd.hold_timeout", 32'(timeout), 1);
      check("wd.hold_finished", 32'(finished), 0);

      // done in the last watchdog cycle wins; empty FIFO goes RUN->DRAIN->FINISHED
      do_reset();
      repeat (19) @(posedge clk);
      #1;
      done = 1'b1;
      @(posedge clk);
      #1;
      done = 1'b0;
      check("race.drain_timeout", 32'(timeout), 0);
      check("race.drain_finished", 32'(finished), 0);
      check("race.drain_cycles", n_cycles, 20);
      @(posedge clk);
      #1;
      check("race.finished", 32'(finished), 1);
      check("race.timeout", 32'(timeout), 0);

      // asynchronous reset mid-drain with three entries queued
      do_reset();
      retire_valid_0 = 1'b1; retire_addr_0 = 32'h70;
      retire_valid_1 = 1'b1; retire_addr_1 = 32'h74;
      @(posedge clk);
      #1;
      retire_addr_0 = 32'h78; retire_valid_1 = 1'b0; done = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
      @(posedge clk);
      #1;
      check_all("ar.pre", 1, 32'h70, 0, 3, 2, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all("ar.async", 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      retire_valid_0 = 1'b1; retire_addr_0 = 32'h80;
      @(posedge clk);
      #1;
      idle_inputs();
      check_all("ar.resume", 1, 32'h80, 0, 1, 1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
